// File: rtl/reg_dump_reader.sv
// Register-file dump engine: walks addresses 0..NUM_REGS-1, streams each
// 32-bit register out little-endian over a valid/ready byte link, then emits
// an XOR checksum of every data byte.
module reg_dump_reader #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0] rd,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StLoad = 3'd1;
  localparam logic [2:0] StSend = 3'd2;
  localparam logic [2:0] StCsum = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_REGS - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [7:0]        csum_q, csum_d;

  // Next-state logic: one LOAD per register, four accepted bytes per register.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    csum_d  = csum_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          idx_d   = '0;
          cnt_d   = '0;
          csum_d  = '0;
        end
      end
      StLoad: begin
        // Snapshot of this register is taken here; later core writes are not seen.
        shreg_d = rd;
        cnt_d   = '0;
        state_d = StSend;
      end
      StSend: begin
        if (out_ready) begin
          csum_d  = csum_q ^ shreg_q[7:0];
          shreg_d = {8'h00, shreg_q[DATA_W-1:8]};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (idx_q == LastIdx) begin
              state_d = StCsum;
            end else begin
              idx_d   = idx_q + ADDR_W'(1);
              state_d = StLoad;
            end
          end
        end
      end
      StCsum: begin
        if (out_ready) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
      shreg_q <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      csum_q  <= csum_d;
    end
  end

  // Outputs decode registered state only; out_ready never reaches them.
  always_comb begin
    busy      = (state_q == StLoad) || (state_q == StSend) || (state_q == StCsum);
    done      = (state_q == StDone);
    ra        = idx_q;
    out_valid = (state_q == StSend) || (state_q == StCsum);
    out_data  = 8'h00;
    if (state_q == StSend) out_data = shreg_q[7:0];
    if (state_q == StCsum) out_data = csum_q;
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Randomized self-checking bench for reg_dump_reader with a register-file model.
module tb_reg_dump_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, out_valid;
  logic [4:0]  ra;
  logic [31:0] rd;
  logic [7:0]  out_data;
  logic        out_ready = 1'b0;

  logic [31:0] rf   [32];
  logic [31:0] snap [32];
  logic [7:0]  got [$];
  logic [7:0]  exp_q [$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int stall_err = 0;
  bit bp_en = 1'b0;
  bit prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  reg_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .ra        (ra),
    .rd        (rd),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign rd = rf[ra];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Random backpressure source (30% ready) when enabled.
  always @(posedge clk) begin
    #1;
    if (bp_en) out_ready = ($urandom_range(0, 9) < 3);
  end

  // Monitor: capture accepted bytes, count done pulses, watch stall stability.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) got.push_back(out_data);
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (prev_stall && (!out_valid || out_data !== prev_data)) stall_err = stall_err + 1;
    prev_stall = rst_n && out_valid && !out_ready;
    prev_data  = out_data;
  end

  // Reference stream: every register's bytes little-endian, then XOR of all bytes.
  task automatic build_expected();
    logic [7:0] cs;
    logic [31:0] w;
    cs = 8'h00;
    exp_q.delete();
    for (int r = 0; r < 32; r++) begin
      w = snap[r];
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back(w[8*b +: 8]);
        cs = cs ^ w[8*b +: 8];
      end
    end
    exp_q.push_back(cs);
  endtask

  task automatic preload();
    for (int r = 0; r < 32; r++) rf[r] = (r == 0) ? 32'h0 : 32'h11223300 + r;
  endtask

  task automatic pulse_start(output int s);
    @(posedge clk); #1;
    start = 1'b1;
    s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, output bit to);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    to = (done_cnt == d0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b want=0", done); else n_pass++;
    n_checks++; if (ra !== 5'd0) $display("FAIL reset_ra got=%0d want=0", ra); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b want=0", out_valid); else n_pass++;
    n_checks++; if (out_data !== 8'h00) $display("FAIL reset_data got=%h want=00", out_data); else n_pass++;
  endtask

  task automatic test_full_dump();
    int s, d0, bad;
    bit to;
    preload();
    for (int r = 0; r < 32; r++) snap[r] = rf[r];
    build_expected();
    got.delete();
    out_ready = 1'b1;
    d0 = done_cnt;
    pulse_start(s);
    wait_done(d0, to);
    n_checks++; if (to) $display("FAIL full_timeout got=timeout want=done"); else n_pass++;
    n_checks++; if (got.size() !== 129) $display("FAIL full_len got=%0d want=129", got.size()); else n_pass++;
    bad = 0;
    for (int i = 0; i < 129 && i < got.size(); i++) if (got[i] !== exp_q[i]) bad++;
    n_checks++; if (bad != 0) $display("FAIL full_bytes got=%0d wrong want=0", bad); else n_pass++;
    n_checks++; if (done_cyc - s != 162) $display("FAIL full_done_latency got=%0d want=162", done_cyc - s); else n_pass++;
    n_checks++; if (done_cnt - d0 != 1) $display("FAIL full_done_count got=%0d want=1", done_cnt - d0); else n_pass++;
  endtask

  task automatic test_backpressure();
    int s, d0, bad;
    bit to;
    preload();
    for (int r = 0; r < 32; r++) snap[r] = rf[r];
    build_expected();
    got.delete();
    stall_err = 0;
    bp_en = 1'b1;
    d0 = done_cnt;
    pulse_start(s);
    wait_done(d0, to);
    bp_en = 1'b0;
    out_ready = 1'b1;
    n_checks++; if (to) $display("FAIL bp_timeout got=timeout want=done"); else n_pass++;
    n_checks++; if (got.size() !== 129) $display("FAIL bp_len got=%0d want=129", got.size()); else n_pass++;
    bad = 0;
    for (int i = 0; i < 129 && i < got.size(); i++) if (got[i] !== exp_q[i]) bad++;
    n_checks++; if (bad != 0) $display("FAIL bp_bytes got=%0d wrong want=0", bad); else n_pass++;
    n_checks++; if (stall_err != 0) $display("FAIL bp_stall_hold got=%0d want=0", stall_err); else n_pass++;
  endtask

  task automatic test_write_during_dump();
    int s, d0, bad;
    bit to;
    preload();
    for (int r = 0; r < 32; r++) snap[r] = rf[r];
    snap[5] = 32'hDEADBEEF;  // x5 not yet loaded when written; x1 already was
    build_expected();
    got.delete();
    out_ready = 1'b1;
    d0 = done_cnt;
    pulse_start(s);
    repeat (11) @(posedge clk);  // register 2 is in SEND now
    #1;
    rf[5] = 32'hDEADBEEF;
    rf[1] = 32'hCAFEF00D;
    wait_done(d0, to);
    n_checks++; if (to) $display("FAIL wr_timeout got=timeout want=done"); else n_pass++;
    n_checks++; if (got.size() !== 129) $display("FAIL wr_len got=%0d want=129", got.size()); else n_pass++;
    bad = 0;
    for (int i = 0; i < 129 && i < got.size(); i++) if (got[i] !== exp_q[i]) bad++;
    n_checks++; if (bad != 0) $display("FAIL wr_bytes got=%0d wrong want=0", bad); else n_pass++;
    if (got.size() >= 24) begin
      n_checks++;
      if ({got[23], got[22], got[21], got[20]} !== 32'hDEADBEEF)
        $display("FAIL wr_x5 got=%h want=deadbeef", {got[23], got[22], got[21], got[20]});
      else n_pass++;
      n_checks++;
      if ({got[7], got[6], got[5], got[4]} !== 32'h11223301)
        $display("FAIL wr_x1_old got=%h want=11223301", {got[7], got[6], got[5], got[4]});
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int s, d0, bad;
    bit to;
    preload();
    out_ready = 1'b1;
    pulse_start(s);
    repeat (53) @(posedge clk);  // register 10 byte 2 on the bus
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got=%b want=0", busy); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_mid_valid got=%b want=0", out_valid); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL rst_mid_done got=%b want=0", done); else n_pass++;
    n_checks++; if (ra !== 5'd0) $display("FAIL rst_mid_ra got=%0d want=0", ra); else n_pass++;
    rst_n = 1'b1;
    for (int r = 0; r < 32; r++) snap[r] = rf[r];
    build_expected();
    got.delete();
    d0 = done_cnt;
    pulse_start(s);
    wait_done(d0, to);
    n_checks++; if (to) $display("FAIL rst_restart_timeout got=timeout want=done"); else n_pass++;
    n_checks++; if (got.size() !== 129) $display("FAIL rst_restart_len got=%0d want=129", got.size()); else n_pass++;
    bad = 0;
    for (int i = 0; i < 129 && i < got.size(); i++) if (got[i] !== exp_q[i]) bad++;
    n_checks++; if (bad != 0) $display("FAIL rst_restart_bytes got=%0d wrong want=0", bad); else n_pass++;
  endtask

  task automatic test_start_busy();
    int s, d0, bad;
    preload();
    for (int r = 0; r < 32; r++) snap[r] = rf[r];
    build_expected();
    got.delete();
    out_ready = 1'b1;
    d0 = done_cnt;
    pulse_start(s);
    repeat (19) @(posedge clk);  // mid-SEND
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (141) @(posedge clk);  // DONE cycle
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    n_checks++; if (done_cnt - d0 != 1) $display("FAIL busy_done_count got=%0d want=1", done_cnt - d0); else n_pass++;
    n_checks++; if (got.size() !== 129) $display("FAIL busy_len got=%0d want=129", got.size()); else n_pass++;
    bad = 0;
    for (int i = 0; i < 129 && i < got.size(); i++) if (got[i] !== exp_q[i]) bad++;
    n_checks++; if (bad != 0) $display("FAIL busy_bytes got=%0d wrong want=0", bad); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL busy_idle_after got=%b want=0", busy); else n_pass++;
  endtask

  task automatic test_checksum_edge();
    int s, d0;
    bit to;
    logic [31:0] last_vals [2];
    logic [7:0]  want_cs [2];
    last_vals[0] = 32'hFFFFFFFF;
    last_vals[1] = 32'h000000A5;
    want_cs[0] = 8'h00;
    want_cs[1] = 8'hA5;
    out_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      for (int r = 0; r < 32; r++) rf[r] = 32'h0;
      rf[31] = last_vals[t];
      for (int r = 0; r < 32; r++) snap[r] = rf[r];
      build_expected();
      got.delete();
      d0 = done_cnt;
      pulse_start(s);
      wait_done(d0, to);
      n_checks++; if (to) $display("FAIL cs_timeout_%0d got=timeout want=done", t); else n_pass++;
      if (got.size() == 129) begin
        n_checks++;
        if (got[128] !== want_cs[t]) $display("FAIL cs_byte_%0d got=%h want=%h", t, got[128], want_cs[t]);
        else n_pass++;
        n_checks++;
        if (got[128] !== exp_q[128]) $display("FAIL cs_model_%0d got=%h want=%h", t, got[128], exp_q[128]);
        else n_pass++;
      end else begin
        n_checks++;
        $display("FAIL cs_len_%0d got=%0d want=129", t, got.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_backpressure();
    test_write_during_dump();
    test_reset_mid();
    test_start_busy();
    test_checksum_edge();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
